// File: rtl/xcvr_cal_sequencer.sv
// rtl/xcvr_cal_sequencer.sv - multi-channel offset-cancellation calibration sequencer
module xcvr_cal_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int AUTO_CAL     = 1,
    parameter int CAL_TIMEOUT  = 1024
) (
    input  logic                    mgmt_clk_clk,
    input  logic                    mgmt_rst_reset_n,
    input  logic [6:0]              reconfig_mgmt_address,
    input  logic                    reconfig_mgmt_read,
    input  logic                    reconfig_mgmt_write,
    input  logic [31:0]             reconfig_mgmt_writedata,
    output logic [31:0]             reconfig_mgmt_readdata,
    output logic                    reconfig_mgmt_waitrequest,
    output logic                    reconfig_busy,
    input  logic                    cal_busy_in,
    output logic [NUM_CHANNELS-1:0] ch_cal_req,
    input  logic [NUM_CHANNELS-1:0] ch_cal_done,
    output logic [NUM_CHANNELS-1:0] tx_cal_busy,
    output logic [NUM_CHANNELS-1:0] rx_cal_busy
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [NUM_CHANNELS-1:0] PEND_RST = (AUTO_CAL != 0) ? {NUM_CHANNELS{1'b1}} : '0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EXT, S_SELECT, S_CAL} state_t;

    state_t                  state, state_n;
    logic [NUM_CHANNELS-1:0] pending, pending_n;
    logic [NUM_CHANNELS-1:0] done_reg, done_n;
    logic [NUM_CHANNELS-1:0] ch_mask;
    logic [CH_W-1:0]         idx, idx_n, sel_idx;
    logic [15:0]             cnt, cnt_n;
    logic [15:0]             timeout_reg;
    logic                    err, err_n;
    logic                    rd_ack;
    logic [31:0]             rd_data;
    logic                    start, abort, err_clr;

    assign start   = reconfig_mgmt_write && (reconfig_mgmt_address == 7'h00) && reconfig_mgmt_writedata[0];
    assign abort   = reconfig_mgmt_write && (reconfig_mgmt_address == 7'h00) && reconfig_mgmt_writedata[1];
    assign err_clr = reconfig_mgmt_write && (reconfig_mgmt_address == 7'h01) && reconfig_mgmt_writedata[1];

    // The read stalls exactly one cycle while readdata is registered; a colliding write defers it.
    assign reconfig_mgmt_waitrequest = reconfig_mgmt_read && !rd_ack;

    // Lowest-numbered pending channel is calibrated next.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = CH_W'(i);
        end
    end

    // Sequencer next-state: run setup, channel walk, done/timeout resolution and abort.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        done_n    = done_reg;
        idx_n     = idx;
        cnt_n     = cnt;
        err_n     = err;
        if (err_clr) err_n = 1'b0;
        if (abort) begin
            state_n   = S_IDLE;
            pending_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n   = S_WAIT_EXT;
                        pending_n = ch_mask;
                        done_n    = '0;
                        idx_n     = '0;
                    end
                end
                S_WAIT_EXT: begin
                    if (!cal_busy_in) state_n = S_SELECT;
                end
                S_SELECT: begin
                    if (pending == '0) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_CAL;
                        idx_n   = sel_idx;
                        cnt_n   = '0;
                    end
                end
                S_CAL: begin
                    cnt_n = cnt + 16'd1;
                    if (ch_cal_done[idx]) begin
                        done_n[idx]    = 1'b1;
                        pending_n[idx] = 1'b0;
                        state_n        = S_SELECT;
                    end else if ((timeout_reg != 16'd0) && (cnt == timeout_reg - 16'd1)) begin
                        err_n          = 1'b1;
                        pending_n[idx] = 1'b0;
                        state_n        = S_SELECT;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Sequencer state plus outputs registered from the next-state values so they align with state.
    always_ff @(posedge mgmt_clk_clk or negedge mgmt_rst_reset_n) begin
        if (!mgmt_rst_reset_n) begin
            state         <= (AUTO_CAL != 0) ? S_WAIT_EXT : S_IDLE;
            pending       <= PEND_RST;
            done_reg      <= '0;
            idx           <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            ch_cal_req    <= '0;
            tx_cal_busy   <= '0;
            rx_cal_busy   <= PEND_RST;
            reconfig_busy <= (AUTO_CAL != 0);
        end else begin
            state         <= state_n;
            pending       <= pending_n;
            done_reg      <= done_n;
            idx           <= idx_n;
            cnt           <= cnt_n;
            err           <= err_n;
            ch_cal_req    <= (state_n == S_CAL) ? (NUM_CHANNELS'(1) << idx_n) : '0;
            tx_cal_busy   <= (state_n == S_CAL) ? (NUM_CHANNELS'(1) << idx_n) : '0;
            rx_cal_busy   <= pending_n;
            reconfig_busy <= (state_n != S_IDLE);
        end
    end

    // Software-configurable channel mask and per-channel timeout.
    always_ff @(posedge mgmt_clk_clk or negedge mgmt_rst_reset_n) begin
        if (!mgmt_rst_reset_n) begin
            ch_mask     <= {NUM_CHANNELS{1'b1}};
            timeout_reg <= 16'(CAL_TIMEOUT);
        end else if (reconfig_mgmt_write) begin
            if (reconfig_mgmt_address == 7'h02) ch_mask <= NUM_CHANNELS'(reconfig_mgmt_writedata);
            if (reconfig_mgmt_address == 7'h04) timeout_reg <= reconfig_mgmt_writedata[15:0];
        end
    end

    // Register read mux.
    always_comb begin
        rd_data = '0;
        case (reconfig_mgmt_address)
            7'h01:   rd_data = {16'd0, 8'(idx), 6'd0, err, reconfig_busy};
            7'h02:   rd_data = 32'(ch_mask);
            7'h03:   rd_data = 32'(done_reg);
            7'h04:   rd_data = {16'd0, timeout_reg};
            default: rd_data = '0;
        endcase
    end

    // Read handshake: capture data in the stall cycle, release it the next.
    always_ff @(posedge mgmt_clk_clk or negedge mgmt_rst_reset_n) begin
        if (!mgmt_rst_reset_n) begin
            rd_ack                 <= 1'b0;
            reconfig_mgmt_readdata <= '0;
        end else if (reconfig_mgmt_read && !reconfig_mgmt_write && !rd_ack) begin
            rd_ack                 <= 1'b1;
            reconfig_mgmt_readdata <= rd_data;
        end else begin
            rd_ack <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xcvr_cal_sequencer.sv
// tb/tb_xcvr_cal_sequencer.sv - scoreboard bench for xcvr_cal_sequencer
module tb_xcvr_cal_sequencer;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   address = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic         waitrequest;
    logic         reconfig_busy;
    logic         cal_busy_in = 1'b0;
    logic [N-1:0] ch_cal_req;
    logic [N-1:0] ch_cal_done = '0;
    logic [N-1:0] tx_cal_busy;
    logic [N-1:0] rx_cal_busy;

    int           n_assert = 0;
    int           n_fail = 0;
    int           exp_q[$];
    int           req_len[N];
    logic [N-1:0] never_done = '0;
    logic [N-1:0] rx_forbid = '0;
    int           resp_delay = 10;
    int           req_cnt = 0;
    logic [N-1:0] prev_req = '0;

    xcvr_cal_sequencer #(.NUM_CHANNELS(N), .AUTO_CAL(1), .CAL_TIMEOUT(1024)) dut (
        .mgmt_clk_clk              (clk),
        .mgmt_rst_reset_n          (rst_n),
        .reconfig_mgmt_address     (address),
        .reconfig_mgmt_read        (read),
        .reconfig_mgmt_write       (write),
        .reconfig_mgmt_writedata   (writedata),
        .reconfig_mgmt_readdata    (readdata),
        .reconfig_mgmt_waitrequest (waitrequest),
        .reconfig_busy             (reconfig_busy),
        .cal_busy_in               (cal_busy_in),
        .ch_cal_req                (ch_cal_req),
        .ch_cal_done               (ch_cal_done),
        .tx_cal_busy               (tx_cal_busy),
        .rx_cal_busy               (rx_cal_busy)
    );

    always #5 clk = ~clk;

    // Channel model answers a request after resp_delay cycles; monitor pops the expected order.
    always @(negedge clk) begin
        int ch;
        ch_cal_done = '0;
        if (ch_cal_req != '0) begin
            req_cnt++;
            if (req_cnt == resp_delay && (ch_cal_req & never_done) == '0) ch_cal_done = ch_cal_req;
        end else begin
            req_cnt = 0;
        end
        if (rst_n) begin
            n_assert++;
            if ((rx_cal_busy & rx_forbid) !== '0) begin
                n_fail++;
                $display("FAIL rx_masked got %b forbidden %b", rx_cal_busy, rx_forbid);
            end
            if (ch_cal_req != '0 && prev_req == '0) begin
                ch = -1;
                for (int i = 0; i < N; i++) if (ch_cal_req[i]) ch = i;
                if (ch >= 0) req_len[ch] = 0;
                n_assert++;
                if (!$onehot(ch_cal_req)) begin
                    n_fail++;
                    $display("FAIL req_onehot got %b required one-hot", ch_cal_req);
                end
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_order got ch %0d required none", ch);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (ch !== e) begin
                        n_fail++;
                        $display("FAIL req_order got ch %0d required ch %0d", ch, e);
                    end
                end
                n_assert++;
                if (tx_cal_busy !== ch_cal_req) begin
                    n_fail++;
                    $display("FAIL tx_busy got %b required %b", tx_cal_busy, ch_cal_req);
                end
            end
            for (int i = 0; i < N; i++) if (ch_cal_req[i]) req_len[i]++;
        end
        prev_req = ch_cal_req;
    end

    task automatic mm_write(input logic [6:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0; writedata = '0;
    endtask

    task automatic mm_read(input logic [6:0] a, output logic [31:0] d);
        bit got = 0;
        d = '0;
        address = a; read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                d = readdata; got = 1;
                break;
            end
        end
        read = 1'b0;
        if (!got) begin
            n_assert++; n_fail++;
            $display("FAIL read_timeout addr %0h still waiting, required data within 8 cycles", a);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!reconfig_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL run_timeout busy still %b after %0d cycles, required 0", reconfig_busy, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cal_busy_in = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_assert++; if (reconfig_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b required 1", reconfig_busy); end
        n_assert++; if (rx_cal_busy !== 4'hF) begin n_fail++; $display("FAIL rst_rx got %h required f", rx_cal_busy); end
        n_assert++; if (ch_cal_req !== 4'h0) begin n_fail++; $display("FAIL rst_req got %h required 0", ch_cal_req); end
        n_assert++; if (tx_cal_busy !== 4'h0) begin n_fail++; $display("FAIL rst_tx got %h required 0", tx_cal_busy); end
        n_assert++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_wait got %b required 0", waitrequest); end
        n_assert++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h required 0", readdata); end
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        rst_n = 1'b1;
    endtask

    task automatic test_auto_run();
        logic [31:0] d;
        wait_idle(500);
        n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL auto_left got %0d required 0", exp_q.size()); end
        address = 7'h03; read = 1'b1;
        #1;
        n_assert++; if (waitrequest !== 1'b1) begin n_fail++; $display("FAIL rd_stall got %b required 1", waitrequest); end
        read = 1'b0;
        @(negedge clk);
        mm_read(7'h03, d);
        n_assert++; if (d !== 32'hF) begin n_fail++; $display("FAIL auto_done got %h required f", d); end
        mm_read(7'h01, d);
        n_assert++; if (d !== 32'h300) begin n_fail++; $display("FAIL auto_status got %h required 300", d); end
        mm_read(7'h02, d);
        n_assert++; if (d !== 32'hF) begin n_fail++; $display("FAIL mask_rst got %h required f", d); end
        mm_read(7'h04, d);
        n_assert++; if (d !== 32'd1024) begin n_fail++; $display("FAIL timeout_rst got %0d required 1024", d); end
        mm_read(7'h00, d);
        n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_rd got %h required 0", d); end
        mm_read(7'h10, d);
        n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h required 0", d); end
    endtask

    task automatic test_ext_busy();
        logic [31:0] d;
        rst_n = 1'b0; cal_busy_in = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_assert++;
            if (ch_cal_req !== 4'h0 || rx_cal_busy !== 4'hF) begin
                n_fail++;
                $display("FAIL ext_hold got req %h rx %h required req 0 rx f", ch_cal_req, rx_cal_busy);
            end
        end
        cal_busy_in = 1'b0;
        wait_idle(500);
        n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ext_left got %0d required 0", exp_q.size()); end
        mm_read(7'h03, d);
        n_assert++; if (d !== 32'hF) begin n_fail++; $display("FAIL ext_done got %h required f", d); end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        mm_write(7'h02, 32'h5);
        rx_forbid = 4'hA;
        exp_q.push_back(0); exp_q.push_back(2);
        mm_write(7'h00, 32'h1);
        wait_idle(500);
        rx_forbid = 4'h0;
        n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mask_left got %0d required 0", exp_q.size()); end
        mm_read(7'h03, d);
        n_assert++; if (d !== 32'h5) begin n_fail++; $display("FAIL mask_done got %h required 5", d); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        mm_write(7'h02, 32'hF);
        mm_write(7'h04, 32'd20);
        never_done = 4'b0010;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        mm_write(7'h00, 32'h1);
        wait_idle(1000);
        never_done = 4'b0000;
        n_assert++; if (req_len[1] != 20) begin n_fail++; $display("FAIL to_len got %0d required 20", req_len[1]); end
        mm_read(7'h01, d);
        n_assert++; if (d !== 32'h302) begin n_fail++; $display("FAIL to_status got %h required 302", d); end
        mm_read(7'h03, d);
        n_assert++; if (d !== 32'hD) begin n_fail++; $display("FAIL to_done got %h required d", d); end
        mm_write(7'h01, 32'h2);
        mm_read(7'h01, d);
        n_assert++; if (d !== 32'h300) begin n_fail++; $display("FAIL w1c got %h required 300", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        bit hit = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        mm_write(7'h00, 32'h1);
        for (int i = 0; i < 500; i++) begin
            if (ch_cal_req === 4'b0100) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        n_assert++; if (!hit) begin n_fail++; $display("FAIL abort_reach got req %h required 4", ch_cal_req); end
        mm_write(7'h00, 32'h2);
        n_assert++; if (ch_cal_req !== 4'h0) begin n_fail++; $display("FAIL abort_req got %h required 0", ch_cal_req); end
        n_assert++; if (reconfig_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b required 0", reconfig_busy); end
        n_assert++; if (rx_cal_busy !== 4'h0) begin n_fail++; $display("FAIL abort_rx got %h required 0", rx_cal_busy); end
        repeat (20) @(negedge clk);
        n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_left got %0d required 0", exp_q.size()); end
        mm_read(7'h03, d);
        n_assert++; if (d !== 32'h3) begin n_fail++; $display("FAIL abort_done got %h required 3", d); end
    endtask

    task automatic test_coincide();
        logic [31:0] d;
        mm_write(7'h02, 32'h1);
        resp_delay = 20;
        exp_q.push_back(0);
        mm_write(7'h00, 32'h1);
        wait_idle(500);
        resp_delay = 10;
        n_assert++; if (req_len[0] != 20) begin n_fail++; $display("FAIL co_len got %0d required 20", req_len[0]); end
        mm_read(7'h03, d);
        n_assert++; if (d !== 32'h1) begin n_fail++; $display("FAIL co_done got %h required 1", d); end
        mm_read(7'h01, d);
        n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL co_status got %h required 0", d); end
    endtask

    initial begin
        test_reset();
        test_auto_run();
        test_ext_busy();
        test_mask();
        test_timeout();
        test_abort();
        test_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
